// File: rtl/serial_divisibility_engine.sv
// serial_divisibility_engine
//
// Serial divisibility and primality checker. A WIDTH-bit operand is captured
// on an accepted start and shifted MSB-first through NUM_DIV residue
// trackers, one per divisor in DIVISORS. After WIDTH shift cycles the block
// pulses done and presents per-divisor divisibility flags plus a primality
// verdict. Results hold until the next done.
//
// Parameters:
//   WIDTH    operand width in bits (>= 2)
//   NUM_DIV  number of divisor channels (>= 1)
//   DIV_W    width of each divisor entry
//   DIVISORS packed divisor list, divisor i = DIVISORS[i*DIV_W +: DIV_W]
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   start      request to check data (ignored while busy)
//   data       operand, captured when start is accepted
//   busy       high while operand bits are being shifted
//   done       one-cycle pulse when results update
//   div_flags  bit i set when the operand is divisible by divisor i
//   is_prime   primality verdict for the last operand
//   rem        final residue per divisor (only with DIVCHK_REMAINDER_EN)
//
// Optional feature: define DIVCHK_REMAINDER_EN to expose the final residues
// on the rem port.

module serial_divisibility_engine #(
  parameter int WIDTH   = 8,
  parameter int NUM_DIV = 5,
  parameter int DIV_W   = 4,
  parameter logic [NUM_DIV*DIV_W-1:0] DIVISORS = {4'd13, 4'd11, 4'd7, 4'd5, 4'd3}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_DIV-1:0]   div_flags,
  output logic                 is_prime
`ifdef DIVCHK_REMAINDER_EN
  ,
  output logic [NUM_DIV*DIV_W-1:0] rem
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CMP_W = (WIDTH > DIV_W) ? WIDTH : DIV_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   residue      [NUM_DIV];
  logic [DIV_W-1:0]   residue_next [NUM_DIV];
  logic [NUM_DIV-1:0] flags_next;
  logic               prime_next;

  // Next residue for every divisor: append the current MSB to the running
  // remainder and subtract the divisor once if it overflows. Because the
  // remainder is always below the divisor, one subtraction is enough.
  always_comb begin
    logic [DIV_W:0] t;
    logic [DIV_W:0] d;
    logic [DIV_W:0] diff;
    t    = '0;
    d    = '0;
    diff = '0;
    flags_next = '0;
    for (int i = 0; i < NUM_DIV; i++) begin
      residue_next[i] = '0;
    end
    for (int i = 0; i < NUM_DIV; i++) begin
      t    = {residue[i], shift_reg[WIDTH-1]};
      d    = {1'b0, DIVISORS[i*DIV_W +: DIV_W]};
      diff = t - d;
      residue_next[i] = (t >= d) ? diff[DIV_W-1:0] : t[DIV_W-1:0];
      flags_next[i]   = (residue_next[i] == '0);
    end
  end

  // Primality verdict from the flags that will be registered on the last
  // shift. Even operands other than 2 are composite; a hit on a divisor only
  // disqualifies the operand when it is not that divisor itself.
  always_comb begin
    prime_next = (operand > WIDTH'(1)) && ((operand == WIDTH'(2)) || operand[0]);
    for (int i = 0; i < NUM_DIV; i++) begin
      if (flags_next[i] &&
          (CMP_W'(operand) != CMP_W'(DIVISORS[i*DIV_W +: DIV_W]))) begin
        prime_next = 1'b0;
      end
    end
  end

  // Control FSM and datapath registers. Results are loaded on the final
  // shift so that done, busy and the new flags all appear WIDTH cycles after
  // the accepting edge; DONE can accept a new start for back-to-back use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      operand   <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_flags <= '0;
      is_prime  <= 1'b0;
      for (int i = 0; i < NUM_DIV; i++) begin
        residue[i] <= '0;
      end
`ifdef DIVCHK_REMAINDER_EN
      rem <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shift_reg <= data;
            operand   <= data;
            bit_cnt   <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            state     <= SHIFT;
            for (int i = 0; i < NUM_DIV; i++) begin
              residue[i] <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
          for (int i = 0; i < NUM_DIV; i++) begin
            residue[i] <= residue_next[i];
          end
          if (bit_cnt == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            div_flags <= flags_next;
            is_prime  <= prime_next;
`ifdef DIVCHK_REMAINDER_EN
            for (int i = 0; i < NUM_DIV; i++) begin
              rem[i*DIV_W +: DIV_W] <= residue_next[i];
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
